rf_mp: RTL and testbench
========================

// Module: rf_mp
// PURPOSE
//  Parametrised multi-port integer register file for the core decode/writeback stages.
//  Supports NUM_RD combinational read ports, NUM_WR write ports and x0 hardwired to zero.
//  Includes a per-register busy scoreboard, set at issue and cleared at writeback, that decode uses to stall on RAW hazards.
// PARAMETERS
//  XLEN      32  data width of each register
//  NUM_REGS  32  register count; power of two, >=2; AW = $clog2(NUM_REGS)
//  NUM_RD    2   read ports
//  NUM_WR    2   write ports; higher index has priority on an address collision
// PORTS
//  clk       in   1              rising-edge clock
//  rst       in   1              async active-high reset
//  rd_addr   in   NUM_RD*AW      read address per port, packed with port 0 in the LSBs
//  rd_data   out  NUM_RD*XLEN    read data per port
//  rd_busy   out  NUM_RD         scoreboard busy bit of rd_addr[i]
//  wr_en     in   NUM_WR         write enable per port
//  wr_addr   in   NUM_WR*AW      write address per port
//  wr_data   in   NUM_WR*XLEN    write data per port
//  sb_set    in   1              mark sb_addr busy (instruction issue)
//  sb_addr   in   AW             destination register being issued
//  any_busy  out  1              OR of all scoreboard bits
// BEHAVIOUR
//  - Reset (async, while rst=1): every register = 0 and every busy bit = 0. Outputs follow combinationally: rd_data=0, rd_busy=0, any_busy=0.
//  - Write: on posedge clk with wr_en[j]=1 and wr_addr[j]!=0, regs[wr_addr[j]] <= wr_data[j].
//  - Write collisions: if two ports write the same address in one cycle, the highest j wins.
//  - x0: writes to x0 are dropped. rd_data for address 0 is always 0, and busy[0] is always 0.
//  - Read: rd_data[i] is the combinational value of regs[rd_addr[i]]. Without bypass, a same-cycle write becomes visible after the edge.
//  - Scoreboard set: on posedge with sb_set=1 and sb_addr!=0, busy[sb_addr] <= 1.
//  - Scoreboard clear: on posedge, busy[wr_addr[j]] <= 0 for every j with wr_en[j]=1.
//  - Set/clear on the same address in the same cycle: set wins, so the entry stays busy for the new producer.
//  - Reset asserted mid-operation: all state clears immediately, independent of clk. Normal operation resumes on the first edge after rst falls.
//  - Widths: addresses are unsigned AW bits; no out-of-range addresses exist because NUM_REGS is a power of two.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//   - If wr_en[j] && wr_addr[j]==rd_addr[i] && rd_addr[i]!=0, rd_data[i] = wr_data[j] in the same cycle, using the same priority as writes.
//   - The matching busy bit is masked in rd_busy[i] for that cycle.
//  RF_BYPASS_EN undefined: reads show pre-edge contents only, with one cycle of write-to-read latency.
// STRUCTURE
//  - Package rf_pkg: XLEN default, NUM_REGS default, AW localparam, typedef logic [XLEN-1:0] xdata_t, typedef logic [AW-1:0] raddr_t.
//  - Sub-module rf_scoreboard holds the busy vector, the set/clear logic and any_busy.
//  - Storage, read muxing and bypass stay in rf_mp.
// TESTING
//  T1: wr port0 x4<=42; next cycle read x4 and x0 -> rd_data = 42 and 0.
//  T2: same cycle, port0 x5<=7 and port1 x5<=9 -> next cycle read x5 = 9.
//  T3: write x0<=0xDEAD -> read x0 = 0; busy stays 0 after sb_set with x0.
//  T4: sb_set x3 -> rd_busy=1 and any_busy=1. Then wr x3<=11 together with sb_set x3 -> still busy. Then a wr x3 alone -> busy clears to 0.
//  T5: write x6<=77 and read x6 in the same cycle -> with RF_BYPASS_EN, 77 before the edge; without it, the old value until the edge.
//  T6: write x7<=5, then pulse rst between edges -> x7 reads 0 and any_busy=0 immediately, before the next edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package rf_pkg;
  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_XLEN-1:0] xdata_t;
  typedef logic [DEF_AW-1:0]   raddr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, set wins on a collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned NUM_WR   = 2,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 any_busy
);

  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
    end
    // Applied after the clears so a re-issue in the writeback cycle keeps the entry busy.
    if (sb_set && sb_addr != '0) busy_next[sb_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign any_busy = |busy;

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with x0 hardwired to zero and a RAW scoreboard.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module rf_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN     = DEF_XLEN,
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 2,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic                   any_busy
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .any_busy (any_busy)
  );

  // Ascending port order: the last non-blocking write wins, giving the highest port priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
          rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_busy[i]              = 1'b0;
        end
      end
`endif
      if (rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: directed scenarios then randomized traffic against a reference model.
module tb_rf_mp;
  import rf_pkg::*;

  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned XW  = DEF_XLEN;
  localparam int unsigned NR  = DEF_NUM_REGS;
  localparam int unsigned AW  = DEF_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XW-1:0] wr_data;
  logic              sb_set;
  raddr_t            sb_addr;
  logic              any_busy;

  xdata_t mregs [NR];
  bit     mbusy [NR];
  int     checks   = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  rf_mp #(
    .XLEN     (XW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .any_busy (any_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural view: a register array plus a busy flag per register.
  function automatic xdata_t exp_data(input int unsigned i);
    int unsigned a = rd_addr[i*AW +: AW];
    xdata_t v = mregs[a];
`ifdef RF_BYPASS_EN
    for (int unsigned j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(a)) v = wr_data[j*XW +: XW];
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(input int unsigned i);
    int unsigned a = rd_addr[i*AW +: AW];
    logic b = mbusy[a];
`ifdef RF_BYPASS_EN
    for (int unsigned j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(a)) b = 1'b0;
`endif
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  function automatic logic exp_any();
    logic b = 1'b0;
    for (int unsigned r = 0; r < NR; r++) b |= mbusy[r];
    return b;
  endfunction

  task automatic model_reset();
    for (int unsigned r = 0; r < NR; r++) begin
      mregs[r] = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int unsigned j = 0; j < NWR; j++) begin
      int unsigned a = wr_addr[j*AW +: AW];
      if (wr_en[j] && a != 0) mregs[a] = wr_data[j*XW +: XW];
    end
    for (int unsigned j = 0; j < NWR; j++)
      if (wr_en[j]) mbusy[wr_addr[j*AW +: AW]] = 1'b0;
    if (sb_set && sb_addr != 0) mbusy[sb_addr] = 1'b1;
    mbusy[0] = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int unsigned i = 0; i < NRD; i++) begin
      chk($sformatf("%s rd_data%0d", tag, i), rd_data[i*XW +: XW], exp_data(i));
      chk($sformatf("%s rd_busy%0d", tag, i), 32'(rd_busy[i]), 32'(exp_busy(i)));
    end
    chk($sformatf("%s any_busy", tag), 32'(any_busy), 32'(exp_any()));
  endtask

  task automatic setw(input int unsigned j, input int unsigned a, input logic [31:0] d);
    wr_en[j]             = 1'b1;
    wr_addr[j*AW +: AW]  = AW'(a);
    wr_data[j*XW +: XW]  = d;
  endtask

  task automatic setrd(input int unsigned i, input int unsigned a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int unsigned a);
    sb_set  = 1'b1;
    sb_addr = AW'(a);
  endtask

  // Called just after a negedge with inputs applied; returns after the next negedge with writes/issue idle.
  task automatic cycle(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    wr_en  = '0;
    sb_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0; rd_addr = '0;
    model_reset();
    #1 setrd(0, 4); setrd(1, 17);
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // T1: simple write then read, plus x0
    setw(0, 4, 32'd42);
    cycle("t1w");
    setrd(0, 4); setrd(1, 0);
    #1 chk("t1 x4", rd_data[31:0], 32'd42);
    chk("t1 x0", rd_data[63:32], 32'd0);

    // T2: write collision, port 1 wins
    setw(0, 5, 32'd7); setw(1, 5, 32'd9);
    cycle("t2w");
    setrd(0, 5);
    #1 chk("t2 x5", rd_data[31:0], 32'd9);

    // T3: x0 ignores writes and issue
    setw(0, 0, 32'hDEAD); issue(0);
    cycle("t3w");
    setrd(0, 0);
    #1 chk("t3 x0", rd_data[31:0], 32'd0);
    chk("t3 busy0", 32'(rd_busy[0]), 32'd0);
    chk("t3 any", 32'(any_busy), 32'd0);

    // T4: scoreboard set, set-beats-clear, then clear
    issue(3);
    cycle("t4a");
    setrd(0, 3);
    #1 chk("t4 busy set", 32'(rd_busy[0]), 32'd1);
    chk("t4 any set", 32'(any_busy), 32'd1);
    setw(0, 3, 32'd11); issue(3);
    cycle("t4b");
    #1 chk("t4 busy kept", 32'(rd_busy[0]), 32'd1);
    chk("t4 x3", rd_data[31:0], 32'd11);
    setw(1, 3, 32'd12);
    cycle("t4c");
    #1 chk("t4 busy clr", 32'(rd_busy[0]), 32'd0);
    chk("t4 any clr", 32'(any_busy), 32'd0);
    chk("t4 x3 new", rd_data[31:0], 32'd12);

    // T5: same-cycle write/read of x6
    setw(0, 6, 32'd77); setrd(1, 6);
`ifdef RF_BYPASS_EN
    #1 chk("t5 pre", rd_data[63:32], 32'd77);
`else
    #1 chk("t5 pre", rd_data[63:32], 32'd0);
`endif
    cycle("t5w");
    #1 chk("t5 post", rd_data[63:32], 32'd77);

    // T6: asynchronous reset between edges
    setw(0, 7, 32'd5); issue(9);
    cycle("t6w");
    setrd(0, 7);
    #1 chk("t6 x7", rd_data[31:0], 32'd5);
    chk("t6 any", 32'(any_busy), 32'd1);
    rst = 1'b1;
    model_reset();
    #1 chk("t6 rst x7", rd_data[31:0], 32'd0);
    chk("t6 rst any", 32'(any_busy), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic; narrow address range half the time to provoke collisions
    for (int n = 0; n < 400; n++) begin
      int unsigned hi = ($urandom_range(0, 1) == 0) ? 7 : NR - 1;
      for (int unsigned j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, hi));
        wr_data[j*XW +: XW] = $urandom;
      end
      for (int unsigned i = 0; i < NRD; i++) setrd(i, $urandom_range(0, hi));
      sb_set  = ($urandom_range(0, 1) != 0);
      sb_addr = AW'($urandom_range(0, hi));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
